// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops words from a show-ahead FIFO and frames them.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    output logic                  rd_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    state_t                state_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_n;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_n;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] sh_n;
    logic                  load;
    logic                  bit_end;
    logic                  tx_n;
    logic                  busy_n;
    logic                  rd_n;
    logic                  done_n;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par;
`endif

    assign bit_end = (cnt == '0);

    // State, datapath and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            tx_o   <= 1'b1;
            rd_o   <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            tx_o   <= tx_n;
            rd_o   <= rd_n;
            busy_o <= busy_n;
            done_o <= done_n;
`ifdef FIFO_UART_TX_PARITY_EN
            if (load) begin
                par <= ^r_data_i;
            end
`endif
        end
    end

    // Next state, bit timer, bit index and shift register
    always_comb begin
        state_n = state;
        idx_n   = idx;
        sh_n    = sh;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty_i) begin
                    load    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                        sh_n  = sh >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!empty_i) begin
                        load    = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            sh_n  = r_data_i;
            idx_n = '0;
        end
        // Timer rests at zero while idle and reloads on each bit boundary
        if (state_n == IDLE) begin
            cnt_n = '0;
        end else if (load || bit_end) begin
            cnt_n = CNT_MAX;
        end else begin
            cnt_n = cnt - 1'b1;
        end
    end

    // Next output values, looked up from the upcoming state
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        rd_n   = load;
        done_n = (state == STOP) && bit_end;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_n = par;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and CLKS_PER_BIT = 4.
// Build with FIFO_UART_TX_PARITY_EN defined to exercise parity frames.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FL  = (DW + 3) * CPB;
`else
    localparam int FL  = (DW + 2) * CPB;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          empty;
    logic [DW-1:0] r_data;
    logic          rd;
    logic          tx;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [32];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    assign empty  = (wr_ptr == rd_ptr);
    assign r_data = mem[rd_ptr];

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .empty_i  (empty),
        .r_data_i (r_data),
        .rd_o     (rd),
        .tx_o     (tx),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    // FIFO pops on the edge that closes a cycle with the strobe high
    always @(posedge clk) begin
        if (rd) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    function automatic logic exp_tx(input logic [DW-1:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= DW) return b[slot-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (slot == DW + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_rd();
        int n;
        n = 0;
        while (rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rd_wait", {31'd0, rd}, 1);
    endtask

    // Entered in the first frame cycle (pop strobe visible)
    task automatic check_frame(input logic [DW-1:0] b, input bit more);
        for (int i = 0; i < FL; i++) begin
            if (i > 0) begin
                tick();
                check("done_mid", {31'd0, done}, 0);
            end
            check("tx", {31'd0, tx}, {31'd0, exp_tx(b, i / CPB)});
            check("busy", {31'd0, busy}, 1);
            check("rd", {31'd0, rd}, {31'd0, i == 0});
        end
        tick();
        check("done", {31'd0, done}, 1);
        check("rd_next", {31'd0, rd}, {31'd0, more});
        check("busy_next", {31'd0, busy}, {31'd0, more});
        check("tx_next", {31'd0, tx}, {31'd0, !more});
        if (!more) begin
            tick();
            check("done_off", {31'd0, done}, 0);
            check("busy_idle", {31'd0, busy}, 0);
            check("tx_idle", {31'd0, tx}, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rd_seen;
        int tx_low;
        int busy_seen;

        // Reset held with a word waiting
        push(8'hA5);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx", {31'd0, tx}, 1);
            check("rst_rd", {31'd0, rd}, 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_done", {31'd0, done}, 0);
        end
        rst = 1'b0;

        // Single byte
        wait_rd();
        check_frame(8'hA5, 1'b0);
        check("pops_a5", rd_ptr, 1);

        // Empty FIFO
        rd_seen = 0;
        tx_low = 0;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd) rd_seen++;
            if (!tx) tx_low++;
            if (busy) busy_seen++;
        end
        check("empty_rd", rd_seen, 0);
        check("empty_tx", tx_low, 0);
        check("empty_busy", busy_seen, 0);

        // Back-to-back
        push(8'h00);
        push(8'hFF);
        wait_rd();
        check_frame(8'h00, 1'b1);
        check_frame(8'hFF, 1'b0);
        check("pops_b2b", rd_ptr, 3);

        // Reset during data bit 3
        push(8'h3C);
        wait_rd();
        repeat (4 * CPB + 1) tick();
        check("pre_rst_tx", {31'd0, tx}, {31'd0, exp_tx(8'h3C, 4)});
        check("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check("arst_tx", {31'd0, tx}, 1);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_rd", {31'd0, rd}, 0);
        check("arst_done", {31'd0, done}, 0);
        push(8'h5A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_rd", {31'd0, rd}, 0);
            check("hold_tx", {31'd0, tx}, 1);
        end
        check("pops_rst", rd_ptr, 4);
        rst = 1'b0;
        wait_rd();
        check_frame(8'h5A, 1'b0);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity frames: 0x07 -> 1, 0x03 -> 0
        push(8'h07);
        push(8'h03);
        wait_rd();
        check_frame(8'h07, 1'b1);
        check_frame(8'h03, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
